// File: rtl/sys_feed_ctrl.sv
// Operand feeder for a 3x3 systolic array. It latches a matrix pair, pulses
// the accumulator clear, streams skewed rows/columns, then drains and signals done.
module sys_feed_ctrl #(
  parameter int DATA_SIZE    = 2,
  parameter int DRAIN_CYCLES = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start_valid,
  output logic                   start_ready,
  input  logic [9*DATA_SIZE-1:0] mat_a,
  input  logic [9*DATA_SIZE-1:0] mat_b,
  input  logic                   abort,
  output logic                   arr_reset,
  output logic [DATA_SIZE-1:0]   a1,
  output logic [DATA_SIZE-1:0]   a2,
  output logic [DATA_SIZE-1:0]   a3,
  output logic [DATA_SIZE-1:0]   b1,
  output logic [DATA_SIZE-1:0]   b2,
  output logic [DATA_SIZE-1:0]   b3,
  output logic                   busy,
  output logic                   done,
  output logic [2:0]             dbg_state
);

  // Handshake: a pair is accepted on a rising edge where start_valid and
  // start_ready are both high; start_ready is high only while idle.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_FEED  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                         state_q, state_d;
  logic [2:0]                     k_q, k_d;
  logic [3:0]                     drain_q, drain_d;
  logic [9*DATA_SIZE-1:0]         mat_a_q, mat_a_d;
  logic [9*DATA_SIZE-1:0]         mat_b_q, mat_b_d;
  logic                           start_ready_q, start_ready_d;
  logic                           busy_q, busy_d;
  logic                           done_q, done_d;
  logic                           arr_reset_q, arr_reset_d;
  logic [2:0][DATA_SIZE-1:0]      a_q, a_d;
  logic [2:0][DATA_SIZE-1:0]      b_q, b_d;

  // Element (r,c) of a packed matrix, or zero when outside the 3x3 window.
  function automatic logic [DATA_SIZE-1:0] elem(input logic [9*DATA_SIZE-1:0] m,
                                                input int r, input int c);
    elem = '0;
    if (r >= 0 && r <= 2 && c >= 0 && c <= 2)
      elem = m[(3*r+c)*DATA_SIZE +: DATA_SIZE];
  endfunction

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    drain_d = drain_q;
    mat_a_d = mat_a_q;
    mat_b_d = mat_b_q;
    case (state_q)
      S_IDLE: begin
        if (start_valid && start_ready_q && !abort) begin
          state_d = S_CLEAR;
          mat_a_d = mat_a;
          mat_b_d = mat_b;
        end
      end
      S_CLEAR: begin
        state_d = S_FEED;
        k_d     = 3'd0;
      end
      S_FEED: begin
        if (k_q == 3'd4) begin
          state_d = S_DRAIN;
          drain_d = 4'(DRAIN_CYCLES - 1);
        end else begin
          k_d = k_q + 3'd1;
        end
      end
      S_DRAIN: begin
        if (drain_q == 4'd0) state_d = S_DONE;
        else                 drain_d = drain_q - 4'd1;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (abort && state_q != S_IDLE) state_d = S_IDLE;
  end

  // Outputs are computed from the next state so they line up with it once registered.
  always_comb begin
    start_ready_d = (state_d == S_IDLE);
    busy_d        = (state_d != S_IDLE);
    done_d        = (state_d == S_DONE);
    arr_reset_d   = (state_d == S_CLEAR);
    a_d           = '0;
    b_d           = '0;
    if (state_d == S_FEED) begin
      for (int i = 0; i < 3; i++) begin
        a_d[i] = elem(mat_a_q, i, int'(k_d) - i);
        b_d[i] = elem(mat_b_q, int'(k_d) - i, i);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      k_q           <= '0;
      drain_q       <= '0;
      mat_a_q       <= '0;
      mat_b_q       <= '0;
      start_ready_q <= 1'b1;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      arr_reset_q   <= 1'b0;
      a_q           <= '0;
      b_q           <= '0;
    end else begin
      state_q       <= state_d;
      k_q           <= k_d;
      drain_q       <= drain_d;
      mat_a_q       <= mat_a_d;
      mat_b_q       <= mat_b_d;
      start_ready_q <= start_ready_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      arr_reset_q   <= arr_reset_d;
      a_q           <= a_d;
      b_q           <= b_d;
    end
  end

  assign start_ready = start_ready_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign arr_reset   = arr_reset_q;
  assign a1          = a_q[0];
  assign a2          = a_q[1];
  assign a3          = a_q[2];
  assign b1          = b_q[0];
  assign b2          = b_q[1];
  assign b3          = b_q[2];
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_sys_feed_ctrl.sv
// Bench for sys_feed_ctrl: two instances (drain 4 and drain 1) share stimulus;
// a job-timeline model checks every cycle, directed literals pin the model.
module tb_sys_feed_ctrl;

  localparam int DS = 2;
  localparam int MW = 9*DS;
  localparam int W  = 4 + 6*DS;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start_valid = 1'b0;
  logic abort = 1'b0;
  logic [MW-1:0] mat_a = '0;
  logic [MW-1:0] mat_b = '0;

  logic sr0, busy0, done0, arst0;
  logic [DS-1:0] a1_0, a2_0, a3_0, b1_0, b2_0, b3_0;
  logic [2:0] dbg0;
  logic sr1, busy1, done1, arst1;
  logic [DS-1:0] a1_1, a2_1, a3_1, b1_1, b2_1, b3_1;
  logic [2:0] dbg1;

  logic [W-1:0] vec0, vec1;
  assign vec0 = {sr0, busy0, done0, arst0, a1_0, a2_0, a3_0, b1_0, b2_0, b3_0};
  assign vec1 = {sr1, busy1, done1, arst1, a1_1, a2_1, a3_1, b1_1, b2_1, b3_1};

  sys_feed_ctrl #(.DATA_SIZE(DS), .DRAIN_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .start_valid(start_valid), .start_ready(sr0),
    .mat_a(mat_a), .mat_b(mat_b), .abort(abort), .arr_reset(arst0),
    .a1(a1_0), .a2(a2_0), .a3(a3_0), .b1(b1_0), .b2(b2_0), .b3(b3_0),
    .busy(busy0), .done(done0), .dbg_state(dbg0)
  );

  sys_feed_ctrl #(.DATA_SIZE(DS), .DRAIN_CYCLES(1)) dut1 (
    .clk(clk), .reset(reset), .start_valid(start_valid), .start_ready(sr1),
    .mat_a(mat_a), .mat_b(mat_b), .abort(abort), .arr_reset(arst1),
    .a1(a1_1), .a2(a2_1), .a3(a3_1), .b1(b1_1), .b2(b2_1), .b3(b3_1),
    .busy(busy1), .done(done1), .dbg_state(dbg1)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // A = [[1,2,3],[0,1,2],[3,0,1]], B = [[2,1,0],[1,3,2],[0,2,1]], element 8 first
  localparam logic [MW-1:0] A_REF = {2'd1, 2'd0, 2'd3, 2'd2, 2'd1, 2'd0, 2'd3, 2'd2, 2'd1};
  localparam logic [MW-1:0] B_REF = {2'd1, 2'd2, 2'd0, 2'd2, 2'd3, 2'd1, 2'd0, 2'd1, 2'd2};

  logic [3*DS-1:0] exp_a[5] = '{6'b01_00_00, 6'b10_00_00, 6'b11_01_11, 6'b00_10_00, 6'b00_00_01};
  logic [3*DS-1:0] exp_b[5] = '{6'b10_00_00, 6'b01_01_00, 6'b00_11_00, 6'b00_10_10, 6'b00_00_01};
  localparam logic [W-1:0] IDLE_VEC = {1'b1, {(W-1){1'b0}}};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: actual %h required %h", name, $time, act, exp);
    end
  endtask

  // Model: jc counts cycles since the accepting edge (0 = idle). Cycle 1 clears,
  // 2..6 feed with k = jc-2, then d drain cycles, and cycle 7+d is done.
  int            jc0 = 0, jc1 = 0;
  logic [MW-1:0] ma0 = '0, mb0 = '0, ma1 = '0, mb1 = '0;

  function automatic int el(input logic [MW-1:0] m, input int r, input int c);
    logic [DS-1:0] v;
    if (r < 0 || r > 2 || c < 0 || c > 2) return 0;
    v = m[(3*r+c)*DS +: DS];
    return int'(v);
  endfunction

  function automatic logic [W-1:0] exp_vec(input int jc, input int d,
                                           input logic [MW-1:0] ma, input logic [MW-1:0] mb);
    int a[3];
    int b[3];
    int k;
    for (int i = 0; i < 3; i++) begin
      a[i] = 0;
      b[i] = 0;
    end
    if (jc >= 2 && jc <= 6) begin
      k = jc - 2;
      for (int i = 0; i < 3; i++) begin
        a[i] = el(ma, i, k - i);
        b[i] = el(mb, k - i, i);
      end
    end
    return {jc == 0, jc != 0, jc == 7 + d, jc == 1,
            DS'(a[0]), DS'(a[1]), DS'(a[2]), DS'(b[0]), DS'(b[1]), DS'(b[2])};
  endfunction

  task automatic step(inout int jc, inout logic [MW-1:0] ma, inout logic [MW-1:0] mb,
                      input int d);
    if (reset) begin
      jc = 0;
      ma = '0;
      mb = '0;
    end else if (jc == 0) begin
      if (start_valid && !abort) begin
        jc = 1;
        ma = mat_a;
        mb = mat_b;
      end
    end else if (abort || jc == 7 + d) begin
      jc = 0;
    end else begin
      jc++;
    end
  endtask

  always begin
    @(posedge clk);
    step(jc0, ma0, mb0, 4);
    step(jc1, ma1, mb1, 1);
    #1;
    check("cycle_d4", vec0, exp_vec(jc0, 4, ma0, mb0));
    check("cycle_d1", vec1, exp_vec(jc1, 1, ma1, mb1));
  end

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Directed job with the reference matrices; optionally scrambles mat_a/mat_b after acceptance.
  task automatic run_literal_job(input bit scramble);
    @(negedge clk);
    start_valid = 1'b1;
    mat_a = A_REF;
    mat_b = B_REF;
    @(posedge clk);
    #2;
    check("clear_pulse_d4", arst0, 1);
    check("clear_pulse_d1", arst1, 1);
    for (int m = 1; m <= 11; m++) begin
      @(negedge clk);
      start_valid = 1'b0;
      if (scramble) begin
        mat_a = MW'($urandom);
        mat_b = MW'($urandom_range(0, (1 << MW) - 1));
      end
      @(posedge clk);
      #2;
      if (m >= 1 && m <= 5) begin
        check("feed_a_d4", {a1_0, a2_0, a3_0}, exp_a[m-1]);
        check("feed_b_d4", {b1_0, b2_0, b3_0}, exp_b[m-1]);
        check("feed_a_d1", {a1_1, a2_1, a3_1}, exp_a[m-1]);
        check("feed_b_d1", {b1_1, b2_1, b3_1}, exp_b[m-1]);
      end
      if (m == 7)  check("done_d1_t8", done1, 1);
      if (m == 10) check("done_d4_t11", done0, 1);
      if (m == 11) check("ready_after_done", sr0, 1);
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #2;
    check("reset_outputs", vec0, IDLE_VEC);
    @(negedge clk);
    reset = 1'b0;

    run_literal_job(1'b1);
    idle_cycles(3);

    // abort and start_valid together while idle: no handshake
    @(negedge clk);
    start_valid = 1'b1;
    abort = 1'b1;
    @(posedge clk);
    #2;
    check("abort_wins_idle", busy0, 0);
    @(negedge clk);
    start_valid = 1'b0;
    abort = 1'b0;

    // back-to-back jobs with start_valid held high
    @(negedge clk);
    start_valid = 1'b1;
    @(posedge clk);
    for (int m = 1; m <= 12; m++) begin
      @(posedge clk);
      #2;
      if (m == 11) check("b2b_ready", sr0, 1);
      if (m == 12) check("b2b_clear_again", arst0, 1);
    end
    @(negedge clk);
    start_valid = 1'b0;
    idle_cycles(20);

    // abort on the third feed cycle
    @(negedge clk);
    start_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    abort = 1'b1;
    @(posedge clk);
    #2;
    check("abort_to_idle", vec0, IDLE_VEC);
    @(negedge clk);
    abort = 1'b0;
    idle_cycles(12);
    run_literal_job(1'b0);
    idle_cycles(3);

    // asynchronous reset in the middle of drain, with a start pending
    @(negedge clk);
    start_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_valid = 1'b0;
    repeat (7) @(posedge clk);
    @(negedge clk);
    #1;
    reset = 1'b1;
    start_valid = 1'b1;
    #1;
    check("async_reset", vec0, IDLE_VEC);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #2;
    check("first_edge_accept", arst0, 1);
    @(negedge clk);
    start_valid = 1'b0;
    idle_cycles(15);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
